regfile_loader: RTL and testbench

Sequencer that initialises and inspects the 8-entry register file over its native port signals. In LOAD mode it accepts a valid/ready word stream and writes registers 0..NUM_REGS-1 in order through the write port. In DUMP mode it walks read port 1 and streams register contents out on a valid/ready interface. It sits between the test/debug host and the register file, and is the initiator on the register file's ports.

---
 rtl/regfile_loader.sv | 120 ++++++++++++
 tb/tb_regfile_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_loader.sv
// Load/dump sequencer for an 8-entry register file: writes a valid/ready word stream
// into registers 0..NUM_REGS-1, or reads them back out as a valid/ready stream.
module regfile_loader #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              dump_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] a1,
    input  logic [DATA_W-1:0] rd1,
    output logic [ADDR_W-1:0] a3,
    output logic              we3,
    output logic [DATA_W-1:0] wd3,
    output logic [2:0]        dbg_state
);

    // Handshakes: a word moves on a rising clk edge where valid & ready are both high;
    // the producer holds data/valid stable until that edge, and ready may change freely.

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        DRD  = 3'd2,
        DOUT = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [DATA_W-1:0] out_data_nx;
    logic              out_valid_nx;
    logic              out_last_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            out_data  <= out_data_nx;
            out_valid <= out_valid_nx;
            out_last  <= out_last_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        out_data_nx  = out_data;
        out_valid_nx = out_valid;
        out_last_nx  = out_last;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nx = LOAD;
                    idx_nx   = '0;
                end else if (dump_start) begin
                    state_nx = DRD;
                    idx_nx   = '0;
                end
            end
            LOAD: begin
                // The last register leaves idx untouched so it never wraps.
                if (in_valid) begin
                    if (idx == LAST_IDX) state_nx = FIN;
                    else                 idx_nx   = idx + 1'b1;
                end
            end
            DRD: begin
                out_data_nx  = rd1;
                out_valid_nx = 1'b1;
                out_last_nx  = (idx == LAST_IDX);
                state_nx     = DOUT;
            end
            DOUT: begin
                if (out_valid && out_ready) begin
                    out_valid_nx = 1'b0;
                    out_last_nx  = 1'b0;
                    if (out_last) begin
                        state_nx = FIN;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        state_nx = DRD;
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == LOAD);
    assign we3       = in_ready & in_valid & ~reset;
    assign a3        = (state == LOAD) ? ADDR_W'(idx) : '0;
    assign wd3       = (state == LOAD) ? in_data : '0;
    assign a1        = (state == DRD) ? ADDR_W'(idx) : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign dbg_state = state;

endmodule

// File: tb/tb_regfile_loader.sv
// Bench for regfile_loader: a table of load/dump operations plus randomized ones,
// checked against a plain array of expected register contents and a word queue.
module tb_regfile_loader;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start, dump_start;
    logic [DATA_W-1:0] in_data;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_ready, out_last;
    logic              busy, done;
    logic [ADDR_W-1:0] a1, a3;
    logic [DATA_W-1:0] rd1, wd3;
    logic              we3;
    logic [2:0]        dbg_state;

    regfile_loader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .dump_start(dump_start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done),
        .a1(a1), .rd1(rd1), .a3(a3), .we3(we3), .wd3(wd3), .dbg_state(dbg_state)
    );

    // clock/reset block and register file attached to the DUT's native ports
    always #5 clk = ~clk;

    logic [DATA_W-1:0] rf [32];
    always @(posedge clk) if (we3) rf[a3] <= wd3;
    assign rd1 = rf[a1];

    // scoreboard
    logic [DATA_W-1:0] exp_regs [NUM_REGS];
    logic [DATA_W-1:0] exp_q [$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // vmode: 0 valid always, 1 valid on odd cycles, 2 random valid and random data
    task automatic run_load(input int vmode, input logic [31:0] base, input int exp_cycles,
                            input bit both_start);
        int k, cyc;
        logic v;
        k = 0;
        cyc = 0;
        @(negedge clk);
        load_start = 1'b1;
        dump_start = both_start;
        @(negedge clk);
        load_start = 1'b0;
        dump_start = 1'b0;
        while (k < NUM_REGS && cyc < 200) begin
            cyc++;
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? cyc[0] : 1'(($urandom_range(0, 1)));
            in_valid = v;
            in_data = (vmode == 2) ? $urandom : 32'(base * k);
            if (both_start) dump_start = 1'($urandom_range(0, 1));
            #1;
            check("load_we3", we3, v);
            check("load_a3", a3, k);
            check("load_wd3", wd3, in_data);
            check("load_in_ready", in_ready, 1);
            check("load_no_out_valid", out_valid, 0);
            if (v) begin
                exp_regs[k] = in_data;
                k++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        dump_start = 1'b0;
        #1;
        check("load_words", k, NUM_REGS);
        check("load_done", done, 1);
        check("load_fin_busy", busy, 1);
        check("load_fin_in_ready", in_ready, 0);
        check("load_fin_we3", we3, 0);
        if (exp_cycles > 0) check("load_cycles", cyc, exp_cycles);
        @(negedge clk);
        #1;
        check("load_idle_done", done, 0);
        check("load_idle_busy", busy, 0);
    endtask

    // rmode: 0 ready always, 1 ready on odd cycles, 2 random ready
    task automatic run_dump(input int rmode, input int exp_busy);
        int cyc, nwords;
        bit fin, prev_valid, prev_ready;
        logic [DATA_W-1:0] prev_data, exp_w;
        logic prev_last, r;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(exp_regs[i]);
        cyc = 0;
        nwords = 0;
        fin = 0;
        prev_valid = 0;
        prev_ready = 0;
        prev_data = '0;
        prev_last = 1'b0;
        @(negedge clk);
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        while (!fin && cyc < 400) begin
            cyc++;
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'(($urandom_range(0, 1)));
            out_ready = r;
            #1;
            if (done) begin
                fin = 1;
            end else begin
                check("dump_busy", busy, 1);
                check("dump_in_ready", in_ready, 0);
                check("dump_we3", we3, 0);
                if (cyc == 1) check("dump_first_cycle_valid", out_valid, 0);
                if (cyc == 2) check("dump_second_cycle_valid", out_valid, 1);
                if (out_valid) begin
                    if (prev_valid && !prev_ready) begin
                        check("dump_stall_data", out_data, prev_data);
                        check("dump_stall_last", out_last, prev_last);
                    end
                    if (r) begin
                        exp_w = exp_q.pop_front();
                        check("dump_data", out_data, exp_w);
                        check("dump_last", out_last, exp_q.size() == 0);
                        nwords++;
                    end
                end
                prev_valid = out_valid;
                prev_ready = r;
                prev_data = out_data;
                prev_last = out_last;
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        check("dump_done", done, 1);
        check("dump_fin_valid", out_valid, 0);
        check("dump_words", nwords, NUM_REGS);
        check("dump_queue_empty", exp_q.size(), 0);
        if (exp_busy > 0) check("dump_busy_cycles", cyc - 1, exp_busy);
        @(negedge clk);
        #1;
        check("dump_idle_done", done, 0);
        check("dump_idle_busy", busy, 0);
    endtask

    typedef struct {
        bit          is_load;
        int          mode;
        logic [31:0] base;
        bit          both;
        int          exp_cycles;
    } op_t;

    op_t ops [8];

    initial begin
        ops[0] = '{1'b1, 0, 32'h11111111, 1'b0, 8};
        ops[1] = '{1'b0, 0, 32'h0, 1'b0, 16};
        ops[2] = '{1'b0, 1, 32'h0, 1'b0, -1};
        ops[3] = '{1'b1, 1, 32'h01010101, 1'b0, 15};
        ops[4] = '{1'b0, 0, 32'h0, 1'b0, 16};
        ops[5] = '{1'b1, 0, 32'h22222222, 1'b1, 8};
        ops[6] = '{1'b1, 2, 32'h0, 1'b0, -1};
        ops[7] = '{1'b0, 2, 32'h0, 1'b0, -1};

        for (int i = 0; i < 32; i++) rf[i] = '0;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
        reset = 1'b1;
        load_start = 1'b0;
        dump_start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hFFFFFFFF;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_a1", a1, 0);
        check("rst_a3", a3, 0);
        check("rst_we3", we3, 0);
        check("rst_wd3", wd3, 0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (ops[i].is_load) run_load(ops[i].mode, ops[i].base, ops[i].exp_cycles, ops[i].both);
            else                run_dump(ops[i].mode, ops[i].exp_cycles);
        end
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) run_load(2, 32'h0, -1, 1'($urandom_range(0, 1)));
            else                           run_dump(2, -1);
        end

        // reset in the middle of a load, after three writes
        run_load(0, 32'h33333333, 8, 1'b0);
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data = 32'hA5A50000 + c;
            exp_regs[c] = in_data;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        reset = 1'b1;
        #1;
        check("abort_we3", we3, 0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("abort_no_done", done, 0);
        end
        for (int i = 0; i < NUM_REGS; i++) check("abort_rf_contents", rf[i], exp_regs[i]);
        run_dump(0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
